// File: rtl/uart_rx_ctrl.sv
// UART receive controller: Rx_EN/baud sequencing, edge-triggered byte capture into a FIFO, error stats.
// Define UART_RX_CTRL_ERRCNT_EN to build the saturating framing/parity error counters.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [2:0]  BAUD_RESET    = 3'b111,
  parameter int unsigned RECONF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] cfg_baud,
  input  logic       cfg_load,
  input  logic [7:0] Rx_DATA,
  input  logic       Rx_VALID,
  input  logic       Rx_FERROR,
  input  logic       Rx_PERROR,
  output logic       Rx_EN,
  output logic [2:0] baud_select,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] ferr_count,
  output logic [7:0] perr_count,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(RECONF_CYCLES);
  localparam logic [CW-1:0] RELOAD  = CW'(RECONF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RECONF = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_OFF;
      cnt         <= '0;
      baud_select <= BAUD_RESET;
    end else begin
      if (cfg_load) baud_select <= cfg_baud;
      if (!enable) begin
        state <= ST_OFF;
      end else begin
        case (state)
          ST_OFF: if (!cfg_load) state <= ST_RUN;
          ST_RUN: begin
            if (cfg_load) begin
              state <= ST_RECONF;
              cnt   <= RELOAD;
            end
          end
          ST_RECONF: begin
            // A new load during reconfiguration restarts the quiet period
            if (cfg_load)          cnt   <= RELOAD;
            else if (cnt == '0)    state <= ST_RUN;
            else                   cnt   <= cnt - CNT_ONE;
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

  assign run   = (state == ST_RUN);
  assign Rx_EN = run;
  assign busy  = (state == ST_RECONF);

  logic v_q;
  always_ff @(posedge clk) begin
    if (!reset) v_q <= 1'b0;
    else        v_q <= Rx_VALID;
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_req, push, pop, full, empty;

  assign push_req = run && Rx_VALID && !v_q && !Rx_FERROR && !Rx_PERROR;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = out_valid && out_ready;
  assign push     = push_req && (!full || pop);

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= Rx_DATA;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (cfg_load)                       overflow <= 1'b0;
      else if (push_req && full && !pop)  overflow <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic f_q, p_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_q        <= 1'b0;
      p_q        <= 1'b0;
      ferr_count <= 8'h00;
      perr_count <= 8'h00;
    end else begin
      f_q <= Rx_FERROR;
      p_q <= Rx_PERROR;
      if (run && Rx_FERROR && !f_q && ferr_count != 8'hFF) ferr_count <= ferr_count + 8'd1;
      if (run && Rx_PERROR && !p_q && perr_count != 8'hFF) perr_count <= perr_count + 8'd1;
    end
  end
`else
  assign ferr_count = 8'h00;
  assign perr_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed scenarios plus a randomized capture/drain phase.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
`ifdef UART_RX_CTRL_ERRCNT_EN
  localparam int EXP_F3   = 3;
  localparam int EXP_P300 = 255;
`else
  localparam int EXP_F3   = 0;
  localparam int EXP_P300 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, cfg_load, out_ready;
  logic [2:0] cfg_baud;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_FERROR, Rx_PERROR;
  logic       Rx_EN, out_valid, overflow, busy;
  logic [2:0] baud_select;
  logic [7:0] out_data, ferr_count, perr_count;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_RESET(3'b111), .RECONF_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_baud(cfg_baud), .cfg_load(cfg_load),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR),
    .Rx_EN(Rx_EN), .baud_select(baud_select), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ferr_count(ferr_count), .perr_count(perr_count),
    .overflow(overflow), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: expected FIFO contents/occupancy, sticky flag, counters
  logic [7:0] exp_q[$];
  int  occ = 0;
  bit  exp_ovf = 0;
  int  exp_ferr = 0, exp_perr = 0;
  bit  model_run = 0, mon_en = 0;
  bit  v_prev = 0, f_prev = 0, p_prev = 0;
  int  npop = 0;
  int  low;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
      if (out_valid && out_ready) begin
        npop++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h expected no byte at %0t", out_data, $time);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      check("ferr_count", {24'd0, ferr_count}, exp_ferr);
      check("perr_count", {24'd0, perr_count}, exp_perr);
    end
  end

  // One clock: predict this cycle's effects from the inputs currently driven
  task automatic tick();
    bit pop, cap;
    pop = out_ready && (occ > 0);
    cap = model_run && Rx_VALID && !v_prev && !Rx_FERROR && !Rx_PERROR;
    @(posedge clk);
    if (cap) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back(Rx_DATA);
        occ++;
      end else begin
        exp_ovf = 1;
      end
    end
    if (pop) occ--;
    if (cfg_load) exp_ovf = 0;
`ifdef UART_RX_CTRL_ERRCNT_EN
    if (model_run && Rx_FERROR && !f_prev && exp_ferr < 255) exp_ferr++;
    if (model_run && Rx_PERROR && !p_prev && exp_perr < 255) exp_perr++;
`endif
    v_prev = Rx_VALID;
    f_prev = Rx_FERROR;
    p_prev = Rx_PERROR;
    #1;
  endtask

  task automatic clear_inputs();
    enable = 0; cfg_load = 0; cfg_baud = 3'b000; out_ready = 0;
    Rx_DATA = 8'h00; Rx_VALID = 0; Rx_FERROR = 0; Rx_PERROR = 0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    occ = 0; exp_ovf = 0; exp_ferr = 0; exp_perr = 0;
    v_prev = 0; f_prev = 0; p_prev = 0; model_run = 0;
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_rx_en"}, {31'd0, Rx_EN}, 0);
    check({tag, "_baud"}, {29'd0, baud_select}, 32'd7);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    check({tag, "_out_data"}, {24'd0, out_data}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_overflow"}, {31'd0, overflow}, 0);
    check({tag, "_ferr"}, {24'd0, ferr_count}, 0);
    check({tag, "_perr"}, {24'd0, perr_count}, 0);
  endtask

  initial begin
    // Reset with random inputs
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      enable = 1'($urandom); cfg_load = 1'($urandom); cfg_baud = 3'($urandom);
      out_ready = 1'($urandom); Rx_DATA = 8'($urandom); Rx_VALID = 1'($urandom);
      Rx_FERROR = 1'($urandom); Rx_PERROR = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check_reset_state("reset");
    clear_inputs();
    clear_model();
    reset = 1;
    mon_en = 1;
    tick();

    // Enable: Rx_EN follows one edge later
    enable = 1;
    check("rx_en_before_run", {31'd0, Rx_EN}, 0);
    tick();
    check("rx_en_run", {31'd0, Rx_EN}, 1);
    model_run = 1;

    // Capture and drain: one pop per rising edge, 1-cycle latency
    out_ready = 1; npop = 0;
    Rx_DATA = 8'hA5; Rx_VALID = 1;
    tick();
    check("a5_latency_valid", {31'd0, out_valid}, 1);
    check("a5_latency_data", {24'd0, out_data}, 32'hA5);
    repeat (19) tick();
    Rx_VALID = 0; repeat (3) tick();
    Rx_DATA = 8'h3C; Rx_VALID = 1;
    tick();
    check("3c_latency_data", {24'd0, out_data}, 32'h3C);
    repeat (19) tick();
    Rx_VALID = 0; repeat (3) tick();
    check("two_pops", npop, 2);

    // Overflow, then push+pop while full
    out_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      Rx_DATA = 8'(i); Rx_VALID = 1; tick();
      Rx_VALID = 0; tick();
    end
    check("overflow_set", {31'd0, overflow}, 1);
    check("head_after_ovf", {24'd0, out_data}, 32'h01);
    Rx_DATA = 8'h06; Rx_VALID = 1; out_ready = 1; tick();
    Rx_VALID = 0; out_ready = 0; tick();
    check("head_after_pushpop", {24'd0, out_data}, 32'h02);
    npop = 0; out_ready = 1; repeat (6) tick(); out_ready = 0;
    check("drain_four", npop, 4);

    // Reconfiguration with an ignored valid edge inside the quiet period
    cfg_baud = 3'b010; cfg_load = 1; tick(); cfg_load = 0; model_run = 0;
    check("reconf_baud", {29'd0, baud_select}, 32'd2);
    check("reconf_busy", {31'd0, busy}, 1);
    low = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin Rx_DATA = 8'h77; Rx_VALID = 1; end
      if (i == 5) Rx_VALID = 0;
      tick();
      if (Rx_EN) break;
      low++;
      check("busy_mirror", {31'd0, busy}, 1);
    end
    model_run = 1;
    check("reconf_low_cycles", low, 16);
    check("reconf_done_busy", {31'd0, busy}, 0);
    check("reconf_ignored_valid", {31'd0, out_valid}, 0);

    // Error edges: counted, never captured
    for (int i = 0; i < 3; i++) begin
      Rx_FERROR = 1; Rx_VALID = 1; Rx_DATA = 8'hEE; tick();
      Rx_FERROR = 0; Rx_VALID = 0; tick();
    end
    for (int i = 0; i < 300; i++) begin
      Rx_PERROR = 1; Rx_VALID = 1; tick();
      Rx_PERROR = 0; Rx_VALID = 0; tick();
    end
    check("ferr_three", {24'd0, ferr_count}, EXP_F3);
    check("perr_saturate", {24'd0, perr_count}, EXP_P300);
    check("errors_no_push", {31'd0, out_valid}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      Rx_VALID  = ($urandom_range(0, 2) == 0);
      Rx_DATA   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      Rx_FERROR = ($urandom_range(0, 15) == 0);
      Rx_PERROR = ($urandom_range(0, 15) == 0);
      tick();
    end
    Rx_VALID = 0; Rx_FERROR = 0; Rx_PERROR = 0; out_ready = 1;
    repeat (6) tick();
    check("random_drained", {31'd0, out_valid}, 0);

    // Disable has priority over cfg_load; FIFO still drains in OFF
    out_ready = 0;
    Rx_DATA = 8'h5A; Rx_VALID = 1; tick(); Rx_VALID = 0; tick();
    Rx_DATA = 8'hC3; Rx_VALID = 1; tick(); Rx_VALID = 0; tick();
    enable = 0; cfg_load = 1; cfg_baud = 3'b101; tick(); cfg_load = 0; model_run = 0;
    check("disable_rx_en", {31'd0, Rx_EN}, 0);
    check("disable_busy", {31'd0, busy}, 0);
    check("disable_baud", {29'd0, baud_select}, 32'd5);
    tick();
    check("stays_off", {31'd0, Rx_EN | busy}, 0);
    npop = 0; out_ready = 1; repeat (4) tick(); out_ready = 0;
    check("drain_in_off", npop, 2);

    // Reset in the middle of reconfiguration discards everything
    enable = 1; tick(); model_run = 1;
    Rx_DATA = 8'h11; Rx_VALID = 1; tick(); Rx_VALID = 0;
    cfg_baud = 3'b001; cfg_load = 1; tick(); cfg_load = 0; model_run = 0;
    tick();
    check("pre_reset_busy", {31'd0, busy}, 1);
    mon_en = 0; reset = 0;
    @(posedge clk); #1;
    check_reset_state("mid_reset");
    clear_model();
    clear_inputs();
    reset = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
